// File: rtl/iter_shift_ctrl.sv
// iter_shift_ctrl: iterative one-bit-per-cycle shifter for SLL/SRL/SRA.
// Stalls the pipeline while shifting and presents the result in a
// one-cycle done slot. The result register doubles as the shift register.
module iter_shift_ctrl #(
    parameter int N  = 32,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [N-1:0]  a,
    input  logic [SW-1:0] shamt,
    output logic [N-1:0]  result,
    output logic          done,
    output logic          busy,
    output logic          stall_req
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  shreg_q, shreg_d;
    logic [1:0]    op_q,    op_d;
    logic [SW-1:0] cnt_q,   cnt_d;

    // Next-state logic: load on accepted start, one bit-step per SHIFT cycle;
    // flush overrides everything but leaves the shift register untouched.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        op_d    = op_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shreg_d = a;
                    op_d    = op;
                    cnt_d   = shamt;
                    // Zero shift and the reserved op finish without stepping.
                    if (shamt == '0 || op == OP_PASS) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                case (op_q)
                    OP_SLL:  shreg_d = {shreg_q[N-2:0], 1'b0};
                    OP_SRL:  shreg_d = {1'b0, shreg_q[N-1:1]};
                    OP_SRA:  shreg_d = {shreg_q[N-1], shreg_q[N-1:1]};
                    default: shreg_d = shreg_q;
                endcase
                // Counter is nonzero on SHIFT entry; the guard keeps it from
                // ever wrapping even if the state were corrupted.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
                if (cnt_q <= SW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            shreg_d = shreg_q;
            op_d    = op_q;
        end
    end

    // State and datapath registers; reset clears the result as well.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            op_q    <= OP_SLL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign result    = shreg_q;
    assign done      = (state_q == S_DONE);
    assign busy      = (state_q == S_SHIFT) || (state_q == S_DONE);
    // Low in DONE so the pipeline advances in the cycle it captures result.
    assign stall_req = ((state_q == S_IDLE) && start) || (state_q == S_SHIFT);

endmodule

// File: tb/tb_iter_shift_ctrl.sv
// Testbench for iter_shift_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_iter_shift_ctrl;

    localparam int N  = 32;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          start;
    logic [1:0]    op;
    logic [N-1:0]  a;
    logic [SW-1:0] shamt;
    logic [N-1:0]  result;
    logic          done;
    logic          busy;
    logic          stall_req;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: either idle holding a value, or one active operation
    // described by its start cycle, operands and effective step count.
    bit           m_act;
    int           m_t0;
    logic [N-1:0] m_a;
    logic [1:0]   m_op;
    int           m_k;
    logic [N-1:0] m_held;

    iter_shift_ctrl #(.N(N), .SW(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .start     (start),
        .op        (op),
        .a         (a),
        .shamt     (shamt),
        .result    (result),
        .done      (done),
        .busy      (busy),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] ref_shift(input logic [1:0] o, input logic [N-1:0] v, input int s);
        case (o)
            2'b00:   return v << s;
            2'b01:   return v >> s;
            2'b10:   return $unsigned($signed(v) >>> s);
            default: return v;
        endcase
    endfunction

    // Expected phase (0 idle, 1 shifting, 2 done) and result for this cycle.
    task automatic model_now(output int st, output logic [N-1:0] res);
        int j;
        if (!m_act) begin
            st  = 0;
            res = m_held;
        end else begin
            j = cyc - m_t0;
            if (j <= m_k) begin
                st  = 1;
                res = ref_shift(m_op, m_a, j - 1);
            end else begin
                st  = 2;
                res = ref_shift(m_op, m_a, m_k);
            end
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
    task automatic step(input bit st_i, input logic [1:0] op_i, input logic [N-1:0] a_i,
                        input logic [SW-1:0] sh_i, input bit fl_i, input bit rs_i,
                        output bit done_seen, output logic [N-1:0] res_seen);
        int           est;
        logic [N-1:0] eres;
        start = st_i; op = op_i; a = a_i; shamt = sh_i; flush = fl_i; rst = rs_i;
        @(negedge clk);
        model_now(est, eres);
        chk("done",      done,      64'(est == 2));
        chk("busy",      busy,      64'(est != 0));
        chk("stall_req", stall_req, 64'((est == 0 && st_i) || est == 1));
        chk("result",    result,    eres);
        done_seen = done;
        res_seen  = result;
        @(posedge clk);
        if (rs_i) begin
            m_act = 0; m_held = '0;
        end else if (fl_i) begin
            m_act = 0; m_held = eres;
        end else if (est == 0 && st_i) begin
            m_act = 1; m_t0 = cyc; m_a = a_i; m_op = op_i;
            m_k   = (op_i == 2'b11) ? 0 : int'(sh_i);
        end else if (est == 2) begin
            m_act = 0; m_held = eres;
        end
        cyc++;
        #1;
    endtask

    task automatic idle_step(output bit d, output logic [N-1:0] r);
        step(0, 2'b00, '0, '0, 0, 0, d, r);
    endtask

    // Issue one operation and wait (bounded) for its done pulse.
    task automatic op_run(input logic [1:0] o, input logic [N-1:0] v, input logic [SW-1:0] s,
                          output int lat, output logic [N-1:0] r);
        bit d;
        step(1, o, v, s, 0, 0, d, r);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            idle_step(d, r);
            if (d) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) chk("op_timeout", 0, 1);
        idle_step(d, r);
    endtask

    initial begin
        bit           d;
        logic [N-1:0] r;
        int           lat;
        int           ndone;
        int           dcyc;
        int           dq[$];

        // Reset
        rst = 1; flush = 0; start = 0; op = 0; a = '0; shamt = '0;
        @(posedge clk); #1;
        m_act = 0; m_held = '0; cyc = 0;
        step(0, 2'b00, '0, '0, 0, 1, d, r);
        idle_step(d, r);
        chk("reset_result", r, 0);

        // SLL 1 by 4
        op_run(2'b00, 32'h0000_0001, 5'd4, lat, r);
        chk("sll_lat", lat, 5);
        chk("sll_res", r, 32'h0000_0010);

        // SRA / SRL by 31
        op_run(2'b10, 32'h8000_0000, 5'd31, lat, r);
        chk("sra_lat", lat, 32);
        chk("sra_res", r, 32'hFFFF_FFFF);
        op_run(2'b01, 32'h8000_0000, 5'd31, lat, r);
        chk("srl_res", r, 32'h0000_0001);

        // Zero shift for every op, reserved op with nonzero shamt
        for (int o = 0; o < 4; o++) begin
            op_run(2'(o), 32'hDEAD_BEEF, 5'd0, lat, r);
            chk("zero_lat", lat, 1);
            chk("zero_res", r, 32'hDEAD_BEEF);
        end
        op_run(2'b11, 32'hDEAD_BEEF, 5'd7, lat, r);
        chk("pass_lat", lat, 1);
        chk("pass_res", r, 32'hDEAD_BEEF);

        // Starts while busy are ignored
        step(1, 2'b00, 32'h0000_0ABC, 5'd10, 0, 0, d, r);
        ndone = 0; dcyc = -1;
        for (int i = 1; i <= 13; i++) begin
            step((i == 3 || i == 11), 2'b01, 32'h1234_5678, 5'd3, 0, 0, d, r);
            if (d) begin
                ndone++;
                dcyc = i;
                chk("ign_res", r, 32'h002A_F000);
            end
        end
        chk("ign_cnt", ndone, 1);
        chk("ign_cyc", dcyc, 11);

        // Flush mid-shift, then a new start right after
        step(1, 2'b01, 32'hF000_0000, 5'd20, 0, 0, d, r);
        for (int i = 1; i <= 5; i++) idle_step(d, r);
        step(0, 2'b00, '0, '0, 1, 0, d, r);
        step(1, 2'b01, 32'h0000_0F00, 5'd2, 0, 0, d, r);
        chk("flush_hold", r, 32'h0780_0000);
        idle_step(d, r); idle_step(d, r); idle_step(d, r);
        chk("flush_next_done", d, 1);
        chk("flush_next_res", r, 32'h0000_03C0);
        idle_step(d, r);

        // Reset mid-shift
        step(1, 2'b01, 32'hF000_0000, 5'd20, 0, 0, d, r);
        for (int i = 1; i <= 5; i++) idle_step(d, r);
        step(0, 2'b00, '0, '0, 0, 1, d, r);
        idle_step(d, r);
        chk("rst_mid_res", r, 0);
        chk("rst_mid_done", d, 0);

        // Back-to-back
        dq.delete();
        for (int i = 0; i <= 7; i++) begin
            if (i == 0)      step(1, 2'b00, 32'h0000_0003, 5'd1, 0, 0, d, r);
            else if (i == 3) step(1, 2'b10, 32'h8000_0040, 5'd2, 0, 0, d, r);
            else             idle_step(d, r);
            if (d) dq.push_back(i);
        end
        chk("b2b_cnt", dq.size(), 2);
        if (dq.size() == 2) begin
            chk("b2b_d0", dq[0], 2);
            chk("b2b_d1", dq[1], 6);
        end
        chk("b2b_res", r, 32'hE000_0010);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            step($urandom_range(0, 2) == 0, 2'($urandom), $urandom, SW'($urandom),
                 $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0, d, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/iter_shift_ctrl.md
# iter_shift_ctrl

Multi-cycle shift controller for the EX stage of the pipelined RISC-V core. It executes SLL/SRL/SRA (and the immediate forms) by applying a single-bit shift step to an internal register once per cycle, counting down the shift amount. This trades a full N-bit barrel shifter for a small iterative datapath. While a shift is in progress it raises a stall request to the hazard unit, and it presents the result in a one-cycle `done` slot.

## Interface
Parameters:
- `N`, 32, operand/result width; must be a power of two, N ≥ 2.
- `SW`, $clog2(N), shift-amount width (5 for N=32).

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  pipeline flush; aborts any operation in progress.
- `start`  in  1  request a shift; sampled only in IDLE.
- `op`  in  2  00 SLL, 01 SRL, 10 SRA, 11 reserved (pass-through).
- `a`  in  N  operand (rs1 value).
- `shamt`  in  SW  shift amount (rs2[SW-1:0] or imm[SW-1:0]).
- `result`  out  N  shifted value; registered.
- `done`  out  1  one-cycle pulse; `result` is valid in this cycle.
- `busy`  out  1  high in SHIFT and DONE.
- `stall_req`  out  1  combinational stall request to the hazard unit.

## Operation
- The FSM has three states:
  - IDLE: waiting for a request.
  - SHIFT: one bit-step per cycle.
  - DONE: result presented.
- IDLE, `start`=1: latch `a` into the shift register and latch `op`; load the counter with `shamt`.
  - If `shamt`=0 or `op`=11, go to DONE.
  - Otherwise go to SHIFT.
- SHIFT, each cycle:
  - SLL: reg ← {reg[N-2:0], 0}.
  - SRL: reg ← {0, reg[N-1:1]}.
  - SRA: reg ← {reg[N-1], reg[N-1:1]}.
  - The counter decrements. When the counter is 1 before decrement, the next state is DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE unconditionally.
- `start` in SHIFT or DONE is ignored. There is no queueing.
- `result` holds its value after DONE until the next accepted `start` overwrites the register.
- `stall_req` = (state==IDLE & `start`) | (state==SHIFT). It is low in DONE, so the pipeline advances in the same cycle it captures `result`.
- Operands `a`, `shamt` and `op` need only be stable in the cycle `start` is sampled.
- Priority per edge, highest first: `rst` > `flush` > FSM.
  - `flush` in any state: next state IDLE, counter cleared, no `done` pulse, `result` register unchanged.
  - `flush` together with `start` in IDLE: the start is discarded.
- Arithmetic: the counter is SW bits wide and never underflows. The maximum shamt is N-1, so `shamt` = N-1 yields N-1 steps.

## Timing
- Reset values:
  - state IDLE
  - `result`=0
  - counter=0
  - `done`=0
  - `busy`=0
  - `stall_req`=0 (with `start`=0)
- Latency with `start` accepted in cycle 0 and shamt=k>0:
  - SHIFT occupies cycles 1..k.
  - DONE in cycle k+1 (`done`=1, `result` valid).
  - IDLE in cycle k+2; a new `start` is accepted in cycle k+2 at the earliest.
- shamt=0 or `op`=11: DONE in cycle 1 with `result`=`a`.
- `stall_req` is high in cycles 0..k, which is k+1 stall cycles, and high in cycle 0 only for shamt=0.
- Reset mid-operation: IDLE on the next edge, `result` cleared, no `done`.
- Throughput: one operation per k+2 cycles.

## Test plan
- SLL, `a`=0x0000_0001, shamt=4 → `done` in cycle 5, `result`=0x0000_0010. `stall_req` high in cycles 0–4, low in cycle 5.
- SRA, `a`=0x8000_0000, shamt=31 → `done` in cycle 32, `result`=0xFFFF_FFFF. SRL with the same inputs → `result`=0x0000_0001.
- shamt=0, `a`=0xDEAD_BEEF, any op; also `op`=11 with shamt=7 → `done` in cycle 1, `result`=0xDEAD_BEEF.
- Start SLL with shamt=10, assert `start` with new operands in cycles 3 and 11 → both ignored. Single `done` in cycle 11, `result` from the first operands only.
- Start SRL with shamt=20:
  - Assert `flush` in cycle 6 → IDLE in cycle 7, no `done`, `stall_req` low. A `start` in cycle 7 is accepted normally.
  - Repeat with `rst` in cycle 6 → `result`=0 in cycle 7.
- Back-to-back operations: SLL shamt=1 then SRA shamt=2, with the second `start` in the first IDLE cycle → `done` pulses in cycles 2 and 6, each result correct.
